// File: rtl/fpu_result_checker_if.sv
// Bus between the FPU stimulus/result side and the result checker.
// The master is the stimulus/result source; the slave is the checker.
interface fpu_result_checker_if #(
  parameter int CNT_W  = 32,
  parameter int PEND_W = 7
);
  logic              IssueValid;
  logic [31:0]       Expected;
  logic [31:0]       Result;
  logic              Clear;
  logic              CmpValid;
  logic [1:0]        CmpClass;
  logic [CNT_W-1:0]  NumM;
  logic [CNT_W-1:0]  NumR;
  logic [CNT_W-1:0]  NumD;
  logic [31:0]       LastBadResult;
  logic [31:0]       LastBadExpected;
  logic [PEND_W-1:0] Pending;

  modport master (
    output IssueValid, Expected, Result, Clear,
    input  CmpValid, CmpClass, NumM, NumR, NumD,
           LastBadResult, LastBadExpected, Pending
  );

  modport slave (
    input  IssueValid, Expected, Result, Clear,
    output CmpValid, CmpClass, NumM, NumR, NumD,
           LastBadResult, LastBadExpected, Pending
  );
endinterface

// File: rtl/fpu_result_checker.sv
// Delays golden results by the FPU latency, classifies each FPU result as
// match / +-1 LSB rounding / mismatch, and keeps saturating statistics.
module fpu_result_checker #(
  parameter int LATENCY = 4,
  parameter int CNT_W   = 32,
  parameter int PEND_W  = 7
) (
  input  logic                 CLK,
  input  logic                 RST,
  fpu_result_checker_if.slave  bus
);
  localparam logic [1:0] CLS_M = 2'b00;
  localparam logic [1:0] CLS_R = 2'b01;
  localparam logic [1:0] CLS_D = 2'b10;

  logic [LATENCY-1:0]       vld_pipe;
  logic [LATENCY-1:0][31:0] exp_pipe;

  logic              cmp;
  logic [31:0]       exp_tail;
  logic [31:0]       diff;
  logic [1:0]        cls;

  logic              cmp_valid;
  logic [1:0]        cmp_class;
  logic [CNT_W-1:0]  num_m, num_r, num_d;
  logic [31:0]       bad_res, bad_exp;
  logic [PEND_W-1:0] pending;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign cmp      = vld_pipe[LATENCY-1];
  assign exp_tail = exp_pipe[LATENCY-1];
  // Modular difference: 0 vs FFFFFFFF wraps to +-1 and counts as rounding.
  assign diff     = bus.Result - exp_tail;

  always_comb begin
    cls = CLS_D;
    if (diff == 32'h0000_0000)
      cls = CLS_M;
    else if (diff == 32'h0000_0001 || diff == 32'hFFFF_FFFF)
      cls = CLS_R;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_pipe <= '0;
      exp_pipe <= '0;
    end else begin
      vld_pipe[0] <= bus.IssueValid;
      exp_pipe[0] <= bus.Expected;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        exp_pipe[i] <= exp_pipe[i-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cmp_valid <= 1'b0;
      cmp_class <= CLS_M;
      pending   <= '0;
    end else begin
      cmp_valid <= cmp;
      if (cmp)
        cmp_class <= cls;
      case ({bus.IssueValid, cmp})
        2'b10:   pending <= pending + PEND_W'(1);
        2'b01:   pending <= pending - PEND_W'(1);
        default: pending <= pending;
      endcase
    end
  end

  // Clear overrides the compare that lands on the same edge.
  always_ff @(posedge CLK) begin
    if (RST || bus.Clear) begin
      num_m   <= '0;
      num_r   <= '0;
      num_d   <= '0;
      bad_res <= '0;
      bad_exp <= '0;
    end else if (cmp) begin
      case (cls)
        CLS_M:   num_m <= sat_inc(num_m);
        CLS_R:   num_r <= sat_inc(num_r);
        default: begin
          num_d   <= sat_inc(num_d);
          bad_res <= bus.Result;
          bad_exp <= exp_tail;
        end
      endcase
    end
  end

  assign bus.CmpValid        = cmp_valid;
  assign bus.CmpClass        = cmp_class;
  assign bus.NumM            = num_m;
  assign bus.NumR            = num_r;
  assign bus.NumD            = num_d;
  assign bus.LastBadResult   = bad_res;
  assign bus.LastBadExpected = bad_exp;
  assign bus.Pending         = pending;
endmodule

// File: tb/tb_fpu_result_checker.sv
// Directed bench for fpu_result_checker: a LATENCY=4 instance with 32-bit
// counters and a second LATENCY=4 instance with 4-bit counters for saturation.
module tb_fpu_result_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  fpu_result_checker_if #(.CNT_W(32), .PEND_W(7)) bus ();
  fpu_result_checker_if #(.CNT_W(4),  .PEND_W(7)) bus4 ();

  fpu_result_checker #(.LATENCY(4), .CNT_W(32), .PEND_W(7)) dut (
    .CLK(clk), .RST(rst), .bus(bus));
  fpu_result_checker #(.LATENCY(4), .CNT_W(4), .PEND_W(7)) dut4 (
    .CLK(clk), .RST(rst), .bus(bus4));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait out the latency, present Result on the compare edge.
  task automatic do_op(input logic [31:0] e, input logic [31:0] r);
    bus.IssueValid = 1'b1; bus.Expected = e;
    tick();
    bus.IssueValid = 1'b0; bus.Expected = 32'h0;
    repeat (3) tick();
    bus.Result = r;
    tick();
    bus.Result = 32'hDEAD_BEEF;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++; if (bus.CmpValid !== 1'b0) begin errors++; $display("FAIL reset_cmpvalid got %0h exp 0", bus.CmpValid); end
    checks++; if (bus.CmpClass !== 2'b00) begin errors++; $display("FAIL reset_cmpclass got %0h exp 0", bus.CmpClass); end
    checks++; if ({bus.NumM, bus.NumR, bus.NumD} !== 96'h0) begin errors++; $display("FAIL reset_counters got %0h/%0h/%0h exp 0", bus.NumM, bus.NumR, bus.NumD); end
    checks++; if ({bus.LastBadResult, bus.LastBadExpected} !== 64'h0) begin errors++; $display("FAIL reset_lastbad got %0h/%0h exp 0", bus.LastBadResult, bus.LastBadExpected); end
    checks++; if (bus.Pending !== 7'd0) begin errors++; $display("FAIL reset_pending got %0d exp 0", bus.Pending); end
    checks++; if (bus4.NumM !== 4'd0) begin errors++; $display("FAIL reset_dut4_numm got %0d exp 0", bus4.NumM); end
    rst = 1'b0;
    tick();
    checks++; if (bus.CmpValid !== 1'b0) begin errors++; $display("FAIL idle_after_reset_cmpvalid got %0h exp 0", bus.CmpValid); end
  endtask

  task automatic test_single_match();
    bus.IssueValid = 1'b1; bus.Expected = 32'h3F80_0000; bus.Result = 32'h1234_5678;
    tick();
    bus.IssueValid = 1'b0;
    checks++; if (bus.Pending !== 7'd1) begin errors++; $display("FAIL match_pending_e0 got %0d exp 1", bus.Pending); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (bus.Pending !== 7'd1 || bus.CmpValid !== 1'b0) begin errors++; $display("FAIL match_wait_e%0d got pend %0d cmpv %0h exp 1/0", i, bus.Pending, bus.CmpValid); end
    end
    bus.Result = 32'h3F80_0000;
    tick();
    bus.Result = 32'hDEAD_BEEF;
    checks++; if (bus.CmpValid !== 1'b1) begin errors++; $display("FAIL match_cmpvalid got %0h exp 1", bus.CmpValid); end
    checks++; if (bus.CmpClass !== 2'b00) begin errors++; $display("FAIL match_class got %0h exp 0", bus.CmpClass); end
    checks++; if (bus.NumM !== 32'd1) begin errors++; $display("FAIL match_numm got %0d exp 1", bus.NumM); end
    checks++; if (bus.NumR !== 32'd0 || bus.NumD !== 32'd0) begin errors++; $display("FAIL match_numr_numd got %0d/%0d exp 0/0", bus.NumR, bus.NumD); end
    checks++; if (bus.Pending !== 7'd0) begin errors++; $display("FAIL match_pending_e4 got %0d exp 0", bus.Pending); end
    tick();
    checks++; if (bus.CmpValid !== 1'b0) begin errors++; $display("FAIL match_pulse_width got %0h exp 0", bus.CmpValid); end
  endtask

  task automatic test_rounding();
    do_op(32'h4049_0FDB, 32'h4049_0FDC);
    checks++; if (bus.CmpValid !== 1'b1 || bus.CmpClass !== 2'b01) begin errors++; $display("FAIL round_up got v%0h c%0h exp v1 c1", bus.CmpValid, bus.CmpClass); end
    do_op(32'h4049_0FDB, 32'h4049_0FDA);
    checks++; if (bus.CmpValid !== 1'b1 || bus.CmpClass !== 2'b01) begin errors++; $display("FAIL round_down got v%0h c%0h exp v1 c1", bus.CmpValid, bus.CmpClass); end
    checks++; if (bus.NumR !== 32'd2) begin errors++; $display("FAIL round_numr got %0d exp 2", bus.NumR); end
    checks++; if ({bus.LastBadResult, bus.LastBadExpected} !== 64'h0) begin errors++; $display("FAIL round_lastbad got %0h/%0h exp 0/0", bus.LastBadResult, bus.LastBadExpected); end
    checks++; if (bus.NumM !== 32'd1 || bus.NumD !== 32'd0) begin errors++; $display("FAIL round_others got %0d/%0d exp 1/0", bus.NumM, bus.NumD); end
  endtask

  task automatic test_wrap_mismatch();
    do_op(32'h0000_0000, 32'hFFFF_FFFF);
    checks++; if (bus.CmpClass !== 2'b01 || bus.NumR !== 32'd3) begin errors++; $display("FAIL wrap_round got c%0h r%0d exp c1 r3", bus.CmpClass, bus.NumR); end
    do_op(32'h7F80_0000, 32'h7FC0_0000);
    checks++; if (bus.CmpClass !== 2'b10) begin errors++; $display("FAIL mism_class got %0h exp 2", bus.CmpClass); end
    checks++; if (bus.NumD !== 32'd1) begin errors++; $display("FAIL mism_numd got %0d exp 1", bus.NumD); end
    checks++; if (bus.LastBadResult !== 32'h7FC0_0000) begin errors++; $display("FAIL mism_lastbadres got %0h exp 7fc00000", bus.LastBadResult); end
    checks++; if (bus.LastBadExpected !== 32'h7F80_0000) begin errors++; $display("FAIL mism_lastbadexp got %0h exp 7f800000", bus.LastBadExpected); end
    tick();
    checks++; if (bus.CmpValid !== 1'b0 || bus.CmpClass !== 2'b10) begin errors++; $display("FAIL idle_class_hold got v%0h c%0h exp v0 c2", bus.CmpValid, bus.CmpClass); end
    do_op(32'h0000_0005, 32'h0000_0005);
    checks++; if (bus.CmpClass !== 2'b00 || bus.LastBadResult !== 32'h7FC0_0000 || bus.LastBadExpected !== 32'h7F80_0000) begin errors++; $display("FAIL match_keeps_lastbad got c%0h %0h/%0h exp c0 7fc00000/7f800000", bus.CmpClass, bus.LastBadResult, bus.LastBadExpected); end
  endtask

  task automatic test_clear();
    bus.Clear = 1'b1;
    tick();
    bus.Clear = 1'b0;
    checks++; if ({bus.NumM, bus.NumR, bus.NumD, bus.LastBadResult, bus.LastBadExpected} !== 160'h0) begin errors++; $display("FAIL clear_stats got %0d/%0d/%0d %0h/%0h exp all 0", bus.NumM, bus.NumR, bus.NumD, bus.LastBadResult, bus.LastBadExpected); end
    checks++; if (bus.CmpClass !== 2'b00) begin errors++; $display("FAIL clear_keeps_class got %0h exp 0", bus.CmpClass); end
  endtask

  task automatic test_back_to_back();
    bit        iss [700];
    bit        cmpv[700];
    bit [31:0] exs [700];
    bit [31:0] rss [700];
    bit [1:0]  cls [700];
    int t = 0, total, pulses = 0, cm = 0, cr = 0, cd = 0, bad = 0, exp_p;
    for (int n = 0; n < 100; n++) begin
      bit [31:0] e, r;
      int k;
      e = $urandom; k = $urandom_range(0, 2);
      case (k)
        0:       r = e;
        1:       r = ($urandom_range(0, 1) == 1) ? e + 32'd1 : e - 32'd1;
        default: r = e + 32'($urandom_range(2, 1000));
      endcase
      iss[t] = 1'b1; exs[t] = e;
      cmpv[t+4] = 1'b1; rss[t+4] = r; cls[t+4] = 2'(k);
      if (k == 0) cm++; else if (k == 1) cr++; else cd++;
      t += 1 + ((n < 20) ? 0 : $urandom_range(0, 3));
    end
    total = t + 4;
    for (int c = 0; c < total; c++) begin
      bus.IssueValid = iss[c];
      bus.Expected   = exs[c];
      bus.Result     = cmpv[c] ? rss[c] : (32'hBAD0_0000 | 32'(c));
      tick();
      exp_p = 0;
      for (int k = 0; k < 4; k++) if (c - k >= 0 && iss[c-k]) exp_p++;
      if (bus.CmpValid) pulses++;
      if (bus.CmpValid !== cmpv[c]) bad++;
      else if (cmpv[c] && bus.CmpClass !== cls[c]) bad++;
      if (bus.Pending !== 7'(exp_p)) bad++;
      if (c == 10) begin
        checks++; if (bus.Pending !== 7'd4) begin errors++; $display("FAIL stream_pending_full got %0d exp 4", bus.Pending); end
      end
    end
    bus.IssueValid = 1'b0; bus.Result = 32'hDEAD_BEEF;
    checks++; if (bad != 0) begin errors++; $display("FAIL stream_cycle_trace got %0d bad cycles exp 0", bad); end
    checks++; if (pulses != 100) begin errors++; $display("FAIL stream_pulses got %0d exp 100", pulses); end
    checks++; if (bus.NumM !== 32'(cm) || bus.NumR !== 32'(cr) || bus.NumD !== 32'(cd)) begin errors++; $display("FAIL stream_counts got %0d/%0d/%0d exp %0d/%0d/%0d", bus.NumM, bus.NumR, bus.NumD, cm, cr, cd); end
    checks++; if (bus.Pending !== 7'd0) begin errors++; $display("FAIL stream_drain_pending got %0d exp 0", bus.Pending); end
  endtask

  task automatic test_reset_midflight();
    int stray = 0;
    for (int i = 0; i < 3; i++) begin
      bus.IssueValid = 1'b1; bus.Expected = 32'hCAFE_0000 + 32'(i);
      tick();
    end
    checks++; if (bus.Pending !== 7'd3) begin errors++; $display("FAIL midrst_pending_before got %0d exp 3", bus.Pending); end
    rst = 1'b1; bus.Clear = 1'b1; bus.IssueValid = 1'b1; bus.Expected = 32'hCAFE_0003;
    tick();
    rst = 1'b0; bus.Clear = 1'b0; bus.IssueValid = 1'b0;
    checks++; if (bus.Pending !== 7'd0 || bus.CmpValid !== 1'b0) begin errors++; $display("FAIL midrst_state got pend %0d v %0h exp 0/0", bus.Pending, bus.CmpValid); end
    checks++; if ({bus.NumM, bus.NumR, bus.NumD, bus.LastBadResult, bus.LastBadExpected} !== 160'h0) begin errors++; $display("FAIL midrst_stats got %0d/%0d/%0d exp 0", bus.NumM, bus.NumR, bus.NumD); end
    for (int i = 0; i < 6; i++) begin
      bus.Result = 32'hCAFE_0000 + 32'(i);
      tick();
      if (bus.CmpValid !== 1'b0 || bus.Pending !== 7'd0) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL midrst_stray_pulses got %0d exp 0", stray); end
    do_op(32'h1111_1111, 32'h1111_1111);
    checks++; if (bus.CmpValid !== 1'b1 || bus.CmpClass !== 2'b00 || bus.NumM !== 32'd1) begin errors++; $display("FAIL midrst_new_op got v%0h c%0h m%0d exp v1 c0 m1", bus.CmpValid, bus.CmpClass, bus.NumM); end
  endtask

  task automatic test_saturation_clear();
    for (int c = 0; c < 24; c++) begin
      bus4.IssueValid = (c < 20);
      bus4.Expected   = 32'(c);
      bus4.Result     = (c >= 4) ? 32'(c - 4) : 32'hDEAD_BEEF;
      tick();
      if (c == 17) begin
        checks++; if (bus4.NumM !== 4'd14) begin errors++; $display("FAIL sat_count_14 got %0d exp 14", bus4.NumM); end
      end
      if (c == 18) begin
        checks++; if (bus4.NumM !== 4'd15) begin errors++; $display("FAIL sat_count_15 got %0d exp 15", bus4.NumM); end
      end
    end
    checks++; if (bus4.NumM !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d exp 15", bus4.NumM); end
    // Mismatch without Clear, then a mismatch with Clear on the compare edge.
    for (int j = 0; j < 2; j++) begin
      bus4.IssueValid = 1'b1; bus4.Expected = 32'h0000_1000;
      tick();
      bus4.IssueValid = 1'b0;
      repeat (3) tick();
      bus4.Result = 32'h0000_2000; bus4.Clear = (j == 1);
      tick();
      bus4.Clear = 1'b0; bus4.Result = 32'hDEAD_BEEF;
      if (j == 0) begin
        checks++; if (bus4.NumD !== 4'd1 || bus4.LastBadResult !== 32'h2000 || bus4.LastBadExpected !== 32'h1000) begin errors++; $display("FAIL sat_mism_noclear got d%0d %0h/%0h exp d1 2000/1000", bus4.NumD, bus4.LastBadResult, bus4.LastBadExpected); end
      end
    end
    checks++; if (bus4.NumD !== 4'd0 || bus4.NumM !== 4'd0) begin errors++; $display("FAIL clear_wins_counts got d%0d m%0d exp 0/0", bus4.NumD, bus4.NumM); end
    checks++; if (bus4.LastBadResult !== 32'h0 || bus4.LastBadExpected !== 32'h0) begin errors++; $display("FAIL clear_wins_lastbad got %0h/%0h exp 0/0", bus4.LastBadResult, bus4.LastBadExpected); end
    checks++; if (bus4.CmpValid !== 1'b1 || bus4.CmpClass !== 2'b10) begin errors++; $display("FAIL clear_still_reports got v%0h c%0h exp v1 c2", bus4.CmpValid, bus4.CmpClass); end
  endtask

  initial begin
    bus.IssueValid = 1'b0; bus.Expected = 32'h0; bus.Result = 32'hDEAD_BEEF; bus.Clear = 1'b0;
    bus4.IssueValid = 1'b0; bus4.Expected = 32'h0; bus4.Result = 32'hDEAD_BEEF; bus4.Clear = 1'b0;
    test_reset();
    test_single_match();
    test_rounding();
    test_wrap_mismatch();
    test_clear();
    test_back_to_back();
    test_reset_midflight();
    test_saturation_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpu_result_checker.md
Name: fpu_result_checker

Overview:
Synthesizable on-chip result checker that sits on the output side of the FPU and closes the loop opened by the stimulus side. A stimulus source presents each golden result alongside the operands it issues. The block delays that golden value by the FPU pipeline latency, compares it against Result, and classifies each comparison as match, rounding error (±1 LSB) or mismatch. It keeps saturating counters for each class and captures the most recent mismatch, so hardware self-test runs report the same statistics the simulation bench does.

Parameters:
LATENCY, 4, FPU cycles from operand sample edge to valid Result edge; legal range 1..64
CNT_W, 32, width of each statistics counter
PEND_W, 7, width of Pending; must satisfy 2^PEND_W > LATENCY

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous active-high reset
IssueValid  input  1  an operation is presented to the FPU at this edge
Expected  input  32  golden result for the operation issued at this edge
Result  input  32  FPU result output
Clear  input  1  synchronous clear of statistics only
CmpValid  output  1  one-cycle pulse: a comparison completed at the last edge
CmpClass  output  2  00 match, 01 rounding, 10 mismatch, 11 never driven
NumM  output  CNT_W  matched count
NumR  output  CNT_W  rounding-error count
NumD  output  CNT_W  mismatch count
LastBadResult  output  32  Result of most recent mismatch
LastBadExpected  output  32  Expected of most recent mismatch
Pending  output  PEND_W  issued operations not yet compared, range 0..LATENCY

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RST). No other clock or reset.
- Reset values: every output is 0. The delay line valid bits are all 0.
- Delay line: LATENCY stages, each holding {valid, 32-bit expected}. It shifts every cycle. Stage 0 loads {IssueValid, Expected}.
- Alignment: if IssueValid is sampled at edge k, Result is sampled at edge k+LATENCY and compared with the stage LATENCY-1 payload.
- Compare edge (the last-stage valid bit is 1):
  - CmpValid is set to 1 for exactly one cycle.
  - CmpClass is updated.
  - The matching counter increments.
- No compare at an edge: CmpValid goes to 0. CmpClass holds its previous value.
- Classification:
  - diff = (Result − Expected) mod 2^32.
  - diff == 0 gives match.
  - diff == 32'h00000001 or diff == 32'hFFFFFFFF gives rounding.
  - Anything else gives mismatch.
  - Pure bit arithmetic: no NaN or sign awareness, and wrap-around is included (0x00000000 vs 0xFFFFFFFF is rounding).
- Mismatch capture: LastBadResult and LastBadExpected are loaded only on a mismatch. Match and rounding never update them.
- Counters: each counter saturates at all-ones and never wraps.
- Clear:
  - Zeroes NumM, NumR, NumD, LastBadResult and LastBadExpected.
  - Does not touch the delay line, Pending, CmpValid or CmpClass.
  - If Clear and a compare happen at the same edge, Clear wins for the counters and capture registers (that comparison is not counted). CmpValid and CmpClass still report it.
- Pending update per edge: +1 on issue, −1 on compare. If both happen at the same edge, Pending is unchanged. It can never exceed LATENCY.
- Back-to-back issue every cycle is fully supported. Throughput is one comparison per cycle.
- RST mid-operation: all in-flight entries are discarded. No CmpValid pulse occurs for operations issued before RST. Counters, capture registers and Pending return to 0. RST has priority over Clear and IssueValid.
- Result is ignored on edges with no compare, so X or garbage there has no effect.

Test Plan:
All scenarios use LATENCY=4 unless stated.

1. Single match: issue with Expected=0x3F800000 at edge 0; Result=0x3F800000 at edge 4 -> CmpValid high one cycle after edge 4 only; CmpClass=00; NumM=1; NumR=NumD=0; Pending goes 1,1,1,1,0.
2. Rounding both ways: Expected=0x40490FDB with Result=0x40490FDC, then Expected=0x40490FDB with Result=0x40490FDA -> CmpClass=01 both times; NumR=2; LastBad registers stay 0.
3. Wrap and mismatch: Expected=0x00000000 with Result=0xFFFFFFFF -> rounding. Expected=0x7F800000 with Result=0x7FC00000 -> CmpClass=10, NumD=1, LastBadResult=0x7FC00000, LastBadExpected=0x7F800000.
4. Streaming: 100 consecutive issues with a random mix of classes, including gaps of 0 to 3 idle cycles -> exactly 100 CmpValid pulses; NumM+NumR+NumD=100; Pending=4 during the continuous run and 0 after drain; no pulses during idle gaps except for in-flight operations.
5. Reset mid-flight: 3 operations issued, RST high at the next edge -> no CmpValid afterwards; all counters 0; Pending=0. A new issue after RST deasserts compares correctly at +4 edges.
6. Saturation and Clear (CNT_W=4): 20 matches -> NumM=15 and holds. Clear asserted on the same edge as a mismatch compare -> NumD=0, LastBad registers 0, CmpClass=10 and CmpValid=1 still reported.
